// File: rtl/ahb_bus_matrix_pkg.sv
// rtl/ahb_bus_matrix_pkg.sv - shared AHB bus matrix encodings, widths and helpers
//
// Purpose : HTRANS/HRESP encodings, default field widths, input-stage state
//           type and the width of the packed address/control hold vector.
// Ports   : none (package).

package ahb_bus_matrix_pkg;

   localparam int DEF_ADDR_WIDTH  = 32;
   localparam int DEF_AUSER_WIDTH = 32;
   localparam int DEF_MID_WIDTH   = 4;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01
   } hresp_t;

   typedef enum logic {
      ST_PASS = 1'b0,
      ST_HOLD = 1'b1
   } pend_state_t;

   // addr + trans(2) + write(1) + size(3) + burst(3) + prot(4) + master + mastlock(1) + auser
   function automatic int hold_width(input int aw, input int uw, input int mw);
      return aw + 2 + 1 + 3 + 3 + 4 + mw + 1 + uw;
   endfunction

endpackage

// File: rtl/ahb_bus_matrix_input_stage_if.sv
// rtl/ahb_bus_matrix_input_stage_if.sv - master-side and decoder-side signals of one input stage
//
// Purpose : bundles the slave-port address phase, the decoder-facing copy of
//           it and the data-phase response path.
// Modports: slave  - the input stage (consumes master/decoder inputs, drives
//                    decoder request and master response)
//           master - the surrounding environment (drives the other direction)

interface ahb_bus_matrix_input_stage_if
   import ahb_bus_matrix_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int AUSER_WIDTH = DEF_AUSER_WIDTH,
   parameter int MID_WIDTH   = DEF_MID_WIDTH
);
   // master address phase
   logic                   HSELS;
   logic [ADDR_WIDTH-1:0]  HADDRS;
   logic [1:0]             HTRANSS;
   logic                   HWRITES;
   logic [2:0]             HSIZES;
   logic [2:0]             HBURSTS;
   logic [3:0]             HPROTS;
   logic [MID_WIDTH-1:0]   HMASTERS;
   logic                   HMASTLOCKS;
   logic [AUSER_WIDTH-1:0] HAUSERS;
   logic                   HREADYS;
   // decoder feedback
   logic                   active_in;
   logic                   readyout_in;
   logic [1:0]             resp_in;
   // decoder request
   logic                   sel_in;
   logic [ADDR_WIDTH-1:0]  addr_in;
   logic [1:0]             trans_in;
   logic                   write_in;
   logic [2:0]             size_in;
   logic [2:0]             burst_in;
   logic [3:0]             prot_in;
   logic [MID_WIDTH-1:0]   master_in;
   logic                   mastlock_in;
   logic [AUSER_WIDTH-1:0] auser_in;
   logic                   held_tran_in;
   logic                   ready_in;
   // master response
   logic                   HREADYOUTS;
   logic [1:0]             HRESPS;

   modport slave (
      input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
             HMASTERS, HMASTLOCKS, HAUSERS, HREADYS,
             active_in, readyout_in, resp_in,
      output sel_in, addr_in, trans_in, write_in, size_in, burst_in, prot_in,
             master_in, mastlock_in, auser_in, held_tran_in, ready_in,
             HREADYOUTS, HRESPS
   );

   modport master (
      output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
             HMASTERS, HMASTLOCKS, HAUSERS, HREADYS,
             active_in, readyout_in, resp_in,
      input  sel_in, addr_in, trans_in, write_in, size_in, burst_in, prot_in,
             master_in, mastlock_in, auser_in, held_tran_in, ready_in,
             HREADYOUTS, HRESPS
   );

endinterface

// File: rtl/ahb_bus_matrix_hold_reg.sv
// rtl/ahb_bus_matrix_hold_reg.sv - address/control holding register with 2:1 output mux
//
// Purpose : stores a packed address-phase vector on i_load and selects either
//           the stored copy or the live vector for the decoder.
// Ports   : i_clk, i_rst (async, active-high), i_load (capture live vector),
//           i_use_hold (drive o_data from the register), i_live, o_data.

module ahb_bus_matrix_hold_reg #(
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_use_hold,
   input  logic [WIDTH-1:0] i_live,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_data;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_data <= '0;
      end else if (i_load) begin
         r_data <= i_live;
      end
   end

   assign o_data = i_use_hold ? r_data : i_live;

endmodule

// File: rtl/ahb_bus_matrix_input_stage.sv
// rtl/ahb_bus_matrix_input_stage.sv - AHB bus matrix per-slave-port input stage
//
// Purpose : passes the master's address phase to the port decoder, or, when
//           the targeted output stage does not grant the port, captures the
//           transfer, replays it from a holding register and stalls the
//           master until the decoder reports the held transfer as accepted.
// Ports   : HCLK, HRESET (async, active-high), bus (slave modport carrying
//           master address phase, decoder request/feedback, master response).

module ahb_bus_matrix_input_stage
   import ahb_bus_matrix_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int AUSER_WIDTH = DEF_AUSER_WIDTH,
   parameter int MID_WIDTH   = DEF_MID_WIDTH
) (
   input logic                         HCLK,
   input logic                         HRESET,
   ahb_bus_matrix_input_stage_if.slave bus
);

   localparam int HOLD_WIDTH = hold_width(ADDR_WIDTH, AUSER_WIDTH, MID_WIDTH);

   pend_state_t           r_state;
   pend_state_t           w_next_state;
   logic                  w_capture;
   logic                  w_pend;
   logic                  w_trans_req;
   logic [HOLD_WIDTH-1:0] w_live;
   logic [HOLD_WIDTH-1:0] w_mux;

   // Only NONSEQ/SEQ are real requests; IDLE/BUSY always pass straight through.
   assign w_trans_req = bus.HSELS & bus.HTRANSS[1];

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_state <= ST_PASS;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Capture only a transfer the master is actually issuing (HREADYS high),
   // so a pending ERROR or wait state never overlaps a capture.
   always_comb begin
      w_next_state = r_state;
      w_capture    = 1'b0;
      case (r_state)
         ST_PASS: begin
            if (bus.HREADYS && w_trans_req && !bus.active_in) begin
               w_capture    = 1'b1;
               w_next_state = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (bus.active_in) begin
               w_next_state = ST_PASS;
            end
         end
         default: w_next_state = ST_PASS;
      endcase
   end

   assign w_pend = (r_state == ST_HOLD);

   assign w_live = {bus.HADDRS, bus.HTRANSS, bus.HWRITES, bus.HSIZES, bus.HBURSTS,
                    bus.HPROTS, bus.HMASTERS, bus.HMASTLOCKS, bus.HAUSERS};

   ahb_bus_matrix_hold_reg #(
      .WIDTH (HOLD_WIDTH)
   ) u_hold_reg (
      .i_clk      (HCLK),
      .i_rst      (HRESET),
      .i_load     (w_capture),
      .i_use_hold (w_pend),
      .i_live     (w_live),
      .o_data     (w_mux)
   );

   assign {bus.addr_in, bus.trans_in, bus.write_in, bus.size_in, bus.burst_in,
           bus.prot_in, bus.master_in, bus.mastlock_in, bus.auser_in} = w_mux;

   // While holding, the replayed transfer is always selected and always
   // presented as a completed address phase.
   assign bus.sel_in       = w_pend | bus.HSELS;
   assign bus.held_tran_in = w_pend;
   assign bus.ready_in     = w_pend | bus.HREADYS;

   // The master sees wait states with OKAY until the held transfer is accepted.
   assign bus.HREADYOUTS   = w_pend ? 1'b0 : bus.readyout_in;
   assign bus.HRESPS       = w_pend ? HRESP_OKAY : bus.resp_in;

endmodule

// File: tb/tb_ahb_bus_matrix_input_stage.sv
// tb/tb_ahb_bus_matrix_input_stage.sv - scoreboard bench for the AHB bus matrix input stage

module tb_ahb_bus_matrix_input_stage;
   import ahb_bus_matrix_pkg::*;

   typedef struct packed {
      logic        sel;
      logic [31:0] addr;
      logic [1:0]  trans;
      logic        write;
      logic [2:0]  size;
      logic [2:0]  burst;
      logic [3:0]  prot;
      logic [3:0]  mid;
      logic        lock;
      logic [31:0] auser;
   } txn_t;

   typedef struct {
      txn_t       f;
      logic       held;
      logic       ready;
      logic       hro;
      logic [1:0] resp;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   txn_t held_txn;

   always #5 clk = ~clk;

   ahb_bus_matrix_input_stage_if #(
      .ADDR_WIDTH  (32),
      .AUSER_WIDTH (32),
      .MID_WIDTH   (4)
   ) bus ();

   ahb_bus_matrix_input_stage #(
      .ADDR_WIDTH  (32),
      .AUSER_WIDTH (32),
      .MID_WIDTH   (4)
   ) dut (
      .HCLK   (clk),
      .HRESET (rst),
      .bus    (bus)
   );

   function automatic txn_t mk(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                               input logic write, input logic [2:0] size, input logic [2:0] burst,
                               input logic [3:0] prot, input logic [3:0] mid, input logic lock,
                               input logic [31:0] auser);
      txn_t t;
      t.sel = sel;   t.addr = addr;   t.trans = trans; t.write = write;
      t.size = size; t.burst = burst; t.prot = prot;   t.mid = mid;
      t.lock = lock; t.auser = auser;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One bus cycle: drive after the rising edge, queue the hand-specified expectation.
   task automatic step(input txn_t t, input logic rdy, input logic act, input logic rdo,
                       input logic [1:0] rsp, input logic r,
                       input logic e_held, input logic e_hro, input logic [1:0] e_resp);
      exp_t e;
      @(posedge clk);
      #1;
      rst             = r;
      bus.HSELS       = t.sel;
      bus.HADDRS      = t.addr;
      bus.HTRANSS     = t.trans;
      bus.HWRITES     = t.write;
      bus.HSIZES      = t.size;
      bus.HBURSTS     = t.burst;
      bus.HPROTS      = t.prot;
      bus.HMASTERS    = t.mid;
      bus.HMASTLOCKS  = t.lock;
      bus.HAUSERS     = t.auser;
      bus.HREADYS     = rdy;
      bus.active_in   = act;
      bus.readyout_in = rdo;
      bus.resp_in     = rsp;
      e.f     = e_held ? held_txn : t;
      if (e_held) e.f.sel = 1'b1;
      e.held  = e_held;
      e.ready = e_held ? 1'b1 : rdy;
      e.hro   = e_hro;
      e.resp  = e_resp;
      exp_q.push_back(e);
   endtask

   // Monitor: compares every queued expectation on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sel_in",       32'(bus.sel_in),       32'(e.f.sel));
            chk("addr_in",      bus.addr_in,           e.f.addr);
            chk("trans_in",     32'(bus.trans_in),     32'(e.f.trans));
            chk("write_in",     32'(bus.write_in),     32'(e.f.write));
            chk("size_in",      32'(bus.size_in),      32'(e.f.size));
            chk("burst_in",     32'(bus.burst_in),     32'(e.f.burst));
            chk("prot_in",      32'(bus.prot_in),      32'(e.f.prot));
            chk("master_in",    32'(bus.master_in),    32'(e.f.mid));
            chk("mastlock_in",  32'(bus.mastlock_in),  32'(e.f.lock));
            chk("auser_in",     bus.auser_in,          e.f.auser);
            chk("held_tran_in", 32'(bus.held_tran_in), 32'(e.held));
            chk("ready_in",     32'(bus.ready_in),     32'(e.ready));
            chk("HREADYOUTS",   32'(bus.HREADYOUTS),   32'(e.hro));
            chk("HRESPS",       32'(bus.HRESPS),       32'(e.resp));
         end
      end
   end

   initial begin
      txn_t ti, ta, tb1, tb2, tc, td;
      ti  = mk(1'b0, 32'h0000_0000, HTRANS_IDLE,   1'b0, 3'd0, 3'd0, 4'h0, 4'h0, 1'b0, 32'h0);
      ta  = mk(1'b1, 32'h0002_0040, HTRANS_NONSEQ, 1'b1, 3'd2, 3'd0, 4'h3, 4'h5, 1'b0, 32'hA5A5_0001);
      tb1 = mk(1'b1, 32'h0003_0080, HTRANS_SEQ,    1'b0, 3'd1, 3'd3, 4'hC, 4'hA, 1'b1, 32'h1234_5678);
      tb2 = mk(1'b0, 32'hFFFF_FFFC, HTRANS_NONSEQ, 1'b1, 3'd0, 3'd1, 4'h1, 4'h2, 1'b0, 32'hDEAD_BEEF);
      tc  = mk(1'b1, 32'h1000_0404, HTRANS_SEQ,    1'b0, 3'd2, 3'd5, 4'h2, 4'h9, 1'b1, 32'h0BAD_F00D);
      td  = mk(1'b0, 32'h0000_8000, HTRANS_NONSEQ, 1'b1, 3'd2, 3'd0, 4'h3, 4'h1, 1'b0, 32'h0);
      held_txn = ti;

      // reset state: pass-through, HREADYOUTS follows readyout_in
      step(ti,  1, 0, 1, HRESP_OKAY,  1, 0, 1, HRESP_OKAY);
      // granted transfer passes through, no capture
      step(ta,  1, 1, 1, HRESP_OKAY,  0, 0, 1, HRESP_OKAY);
      step(ta,  1, 1, 0, HRESP_OKAY,  0, 0, 0, HRESP_OKAY);
      // not granted: captured, held for three cycles while master inputs change
      held_txn = ta;
      step(ta,  1, 0, 1, HRESP_OKAY,  0, 0, 1, HRESP_OKAY);
      step(tb1, 1, 0, 1, HRESP_ERROR, 0, 1, 0, HRESP_OKAY);
      step(tb2, 0, 0, 0, HRESP_OKAY,  0, 1, 0, HRESP_OKAY);
      step(tb1, 1, 1, 1, HRESP_OKAY,  0, 1, 0, HRESP_OKAY);
      // released; IDLE with no grant is not captured
      step(ti,  1, 0, 1, HRESP_OKAY,  0, 0, 1, HRESP_OKAY);
      step(ti,  1, 0, 1, HRESP_OKAY,  0, 0, 1, HRESP_OKAY);
      // HREADYS low: no capture, ready_in low
      step(ta,  0, 0, 0, HRESP_OKAY,  0, 0, 0, HRESP_OKAY);
      step(ti,  1, 1, 1, HRESP_OKAY,  0, 0, 1, HRESP_OKAY);
      // two-cycle ERROR forwarded unchanged
      step(ta,  0, 0, 0, HRESP_ERROR, 0, 0, 0, HRESP_ERROR);
      step(ti,  1, 0, 1, HRESP_ERROR, 0, 0, 1, HRESP_ERROR);
      // SEQ locked transfer held with its original HTRANS and HMASTLOCK
      held_txn = tc;
      step(tc,  1, 0, 1, HRESP_OKAY,  0, 0, 1, HRESP_OKAY);
      step(tb2, 1, 1, 1, HRESP_OKAY,  0, 1, 0, HRESP_OKAY);
      step(ti,  1, 0, 1, HRESP_OKAY,  0, 0, 1, HRESP_OKAY);
      // unselected NONSEQ not captured
      step(td,  1, 0, 1, HRESP_OKAY,  0, 0, 1, HRESP_OKAY);
      step(ti,  1, 0, 1, HRESP_OKAY,  0, 0, 1, HRESP_OKAY);
      // reset between edges while holding clears the hold at once
      step(tc,  1, 0, 1, HRESP_OKAY,  0, 0, 1, HRESP_OKAY);
      step(tb1, 1, 0, 1, HRESP_ERROR, 0, 1, 0, HRESP_OKAY);
      step(tb1, 1, 0, 1, HRESP_ERROR, 1, 0, 1, HRESP_ERROR);
      step(ti,  1, 0, 1, HRESP_OKAY,  0, 0, 1, HRESP_OKAY);

      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
